// File: rtl/nmr_bus_voter_pkg.sv
// Shared constants and helpers for the N-modular-redundancy AHB bus voter.
package nmr_bus_voter_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   // Bits needed to index N replicas; never less than 1.
   function automatic int rep_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nmr_bus_voter_vote.sv
// Masked strict-majority vote over N replica copies of one W-bit field,
// falling back to the lowest-index active replica when no majority exists.
module nmr_vote
   import nmr_bus_voter_pkg::*;
#(
   parameter int N = 3,
   parameter int W = 1
) (
   input  logic [N-1:0][W-1:0] val_i,
   input  logic [N-1:0]        act_i,
   output logic [W-1:0]        val_o,
   output logic                no_maj_o,
   output logic [N-1:0]        differ_o
);

   localparam int NW = rep_idx_w(N) + 1;

   logic [NW-1:0]        n_act;
   logic [N-1:0][NW-1:0] n_agree;

   always_comb begin
      n_act   = '0;
      n_agree = '0;
      for (int i = 0; i < N; i++) begin
         n_act = n_act + NW'(act_i[i]);
         for (int j = 0; j < N; j++) begin
            if (act_i[j] && (val_i[j] == val_i[i])) n_agree[i] = n_agree[i] + NW'(1);
         end
      end

      // Descending scan leaves the lowest-index active value as the fallback.
      val_o    = '0;
      no_maj_o = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (act_i[i]) val_o = val_i[i];
      end
      for (int i = 0; i < N; i++) begin
         if (act_i[i] && no_maj_o && ({n_agree[i], 1'b0} > {1'b0, n_act})) begin
            val_o    = val_i[i];
            no_maj_o = 1'b0;
         end
      end

      differ_o = '0;
      for (int i = 0; i < N; i++) differ_o[i] = act_i[i] && (val_i[i] != val_o);
   end

endmodule

// File: rtl/nmr_bus_voter.sv
// N-modular-redundancy voter for one AHB master port: votes address/data
// phases over trusted replicas, masks persistent dissenters down to DMR.
module nmr_bus_voter
   import nmr_bus_voter_pkg::*;
#(
   parameter int N  = 3,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int PW = 6,
   parameter int TH = 4,
   parameter int CW = 3
) (
   input  logic                 s_clk_i,
   input  logic                 s_resetn_i,
   input  logic [N-1:0][1:0]    s_rep_htrans_i,
   input  logic [N-1:0][AW-1:0] s_rep_haddr_i,
   input  logic [N-1:0][2:0]    s_rep_hsize_i,
   input  logic [N-1:0]         s_rep_hwrite_i,
   input  logic [N-1:0][PW-1:0] s_rep_hparity_i,
   input  logic [N-1:0][DW-1:0] s_rep_hwdata_i,
   input  logic                 s_hready_i,
   input  logic                 s_clear_i,
   output logic [1:0]           s_htrans_o,
   output logic [AW-1:0]        s_haddr_o,
   output logic [2:0]           s_hsize_o,
   output logic                 s_hwrite_o,
   output logic [PW-1:0]        s_hparity_o,
   output logic [DW-1:0]        s_hwdata_o,
   output logic [N-1:0]         s_rep_masked_o,
   output logic [N-1:0]         s_rep_disagree_o,
   output logic                 s_degraded_o,
   output logic                 s_unrec_err_o
);

   localparam int            NW         = rep_idx_w(N) + 1;
   localparam logic [CW-1:0] TH_C       = CW'(TH);
   localparam logic [NW-1:0] MIN_VOTERS = NW'(3);

   logic [N-1:0]         mask_q, mask_d;
   logic [N-1:0][CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]         disagree_q, disagree_d;
   logic                 dphase_q, dphase_d;
   logic                 err_q, err_d;

   logic [N-1:0]  act;
   logic [NW-1:0] n_act_now, n_left;
   logic          chk_addr, nomaj_ev;
   logic [N-1:0]  mism;
   logic          nm_trans, nm_addr, nm_size, nm_write, nm_par, nm_wdata;
   logic [N-1:0]  df_trans, df_addr, df_size, df_write, df_par, df_wdata;

   assign act = ~mask_q;

   nmr_vote #(.N(N), .W(2)) u_vote_trans (
      .val_i(s_rep_htrans_i), .act_i(act), .val_o(s_htrans_o),
      .no_maj_o(nm_trans), .differ_o(df_trans));

   nmr_vote #(.N(N), .W(AW)) u_vote_addr (
      .val_i(s_rep_haddr_i), .act_i(act), .val_o(s_haddr_o),
      .no_maj_o(nm_addr), .differ_o(df_addr));

   nmr_vote #(.N(N), .W(3)) u_vote_size (
      .val_i(s_rep_hsize_i), .act_i(act), .val_o(s_hsize_o),
      .no_maj_o(nm_size), .differ_o(df_size));

   nmr_vote #(.N(N), .W(1)) u_vote_write (
      .val_i(s_rep_hwrite_i), .act_i(act), .val_o(s_hwrite_o),
      .no_maj_o(nm_write), .differ_o(df_write));

   nmr_vote #(.N(N), .W(PW)) u_vote_par (
      .val_i(s_rep_hparity_i), .act_i(act), .val_o(s_hparity_o),
      .no_maj_o(nm_par), .differ_o(df_par));

   nmr_vote #(.N(N), .W(DW)) u_vote_wdata (
      .val_i(s_rep_hwdata_i), .act_i(act), .val_o(s_hwdata_o),
      .no_maj_o(nm_wdata), .differ_o(df_wdata));

   always_comb begin
      n_act_now = '0;
      for (int i = 0; i < N; i++) n_act_now = n_act_now + NW'(act[i]);
      s_degraded_o = (n_act_now < MIN_VOTERS);
   end

   always_comb begin
      chk_addr = (s_htrans_o != HTRANS_IDLE);
      nomaj_ev = nm_trans
               | (chk_addr & (nm_addr | nm_size | nm_write | nm_par))
               | (dphase_q & nm_wdata);
      // A dissent only counts when the vote itself was decisive.
      mism = act
           & (df_trans
              | ({N{chk_addr}} & (df_addr | df_size | df_write | df_par))
              | ({N{dphase_q}} & df_wdata))
           & {N{~nomaj_ev}};

      cnt_d = cnt_q;
      for (int i = 0; i < N; i++) begin
         if (!mask_q[i]) begin
            if (mism[i]) cnt_d[i] = (cnt_q[i] >= TH_C) ? TH_C : cnt_q[i] + CW'(1);
            else         cnt_d[i] = '0;
         end
      end

      // Mask in ascending order but never drop below two voters.
      mask_d = mask_q;
      n_left = n_act_now;
      for (int i = 0; i < N; i++) begin
         if (!mask_q[i] && (cnt_d[i] == TH_C) && (n_left >= MIN_VOTERS)) begin
            mask_d[i] = 1'b1;
            n_left    = n_left - NW'(1);
         end
      end

      if (s_clear_i) begin
         cnt_d  = '0;
         mask_d = '0;
      end

      disagree_d = mism;
      err_d      = err_q | nomaj_ev;
      dphase_d   = s_hready_i ? (chk_addr & s_hwrite_o) : dphase_q;
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         mask_q     <= '0;
         cnt_q      <= '0;
         disagree_q <= '0;
         dphase_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         disagree_q <= disagree_d;
         dphase_q   <= dphase_d;
         err_q      <= err_d;
      end
   end

   assign s_rep_masked_o   = mask_q;
   assign s_rep_disagree_o = disagree_q;
   assign s_unrec_err_o    = err_q;

endmodule

// File: tb/tb_nmr_bus_voter.sv
// Self-checking bench for nmr_bus_voter (N=3, TH=4): scenario tasks with a
// scoreboard queue of expected registered status per driven cycle.
module tb_nmr_bus_voter;
   localparam int N = 3, AW = 32, DW = 32, PW = 6, TH = 4, CW = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [N-1:0][1:0]    rt;
   logic [N-1:0][AW-1:0] ra;
   logic [N-1:0][2:0]    rs;
   logic [N-1:0]         rw;
   logic [N-1:0][PW-1:0] rp;
   logic [N-1:0][DW-1:0] rd;
   logic hready = 1'b1;
   logic clr = 1'b0;

   logic [1:0]    htrans_o;
   logic [AW-1:0] haddr_o;
   logic [2:0]    hsize_o;
   logic          hwrite_o;
   logic [PW-1:0] hparity_o;
   logic [DW-1:0] hwdata_o;
   logic [N-1:0]  masked_o, disagree_o;
   logic          degraded_o, err_o;

   nmr_bus_voter #(.N(N), .AW(AW), .DW(DW), .PW(PW), .TH(TH), .CW(CW)) dut (
      .s_clk_i(clk), .s_resetn_i(rstn),
      .s_rep_htrans_i(rt), .s_rep_haddr_i(ra), .s_rep_hsize_i(rs),
      .s_rep_hwrite_i(rw), .s_rep_hparity_i(rp), .s_rep_hwdata_i(rd),
      .s_hready_i(hready), .s_clear_i(clr),
      .s_htrans_o(htrans_o), .s_haddr_o(haddr_o), .s_hsize_o(hsize_o),
      .s_hwrite_o(hwrite_o), .s_hparity_o(hparity_o), .s_hwdata_o(hwdata_o),
      .s_rep_masked_o(masked_o), .s_rep_disagree_o(disagree_o),
      .s_degraded_o(degraded_o), .s_unrec_err_o(err_o));

   always #5 clk = ~clk;

   typedef struct {
      string        nm;
      logic [N-1:0] dis;
      logic [N-1:0] msk;
      logic         deg;
      logic         err;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   n_chk = 0;
   int   n_fail = 0;

   wire [2*N+1:0] regs = {disagree_o, masked_o, degraded_o, err_o};

   task automatic drive_all(input logic [1:0] t, input logic [AW-1:0] a,
                            input logic w, input logic [DW-1:0] d);
      for (int i = 0; i < N; i++) begin
         rt[i] = t; ra[i] = a; rs[i] = 3'd2; rw[i] = w;
         rp[i] = PW'(a) ^ 6'h2A; rd[i] = d;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0; clr = 1'b0; hready = 1'b1;
      drive_all(2'b00, '0, 1'b0, '0);
      #12;
      n_chk++;
      if (regs !== '0) begin
         n_fail++; $display("FAIL reset_state: dis/msk/deg/err=%b required %b", regs, {(2*N+2){1'b0}});
      end
      n_chk++;
      if (htrans_o !== 2'b00) begin
         n_fail++; $display("FAIL reset_htrans: got %b required 00", htrans_o);
      end
      @(negedge clk) rstn = 1'b1;
      tick;
   endtask

   task automatic test_clean_write;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive_all(2'b10, 32'h100, 1'b1, '0);
         else        drive_all(2'b00, 32'h100, 1'b0, 32'hDEADBEEF);
         #1;
         n_chk++;
         if ({htrans_o, haddr_o, hwrite_o, hwdata_o} !==
             {(k == 0) ? 2'b10 : 2'b00, 32'h100, (k == 0), (k == 0) ? 32'h0 : 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL clean_bus k=%0d: htrans=%b haddr=%h hwrite=%b hwdata=%h", k, htrans_o, haddr_o, hwrite_o, hwdata_o);
         end
         sbq.push_back('{"clean_status", 3'b000, 3'b000, 1'b0, 1'b0});
         tick;
         e = sbq.pop_front(); n_chk++;
         if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
            n_fail++; $display("FAIL %s k=%0d: dis/msk/deg/err=%b required %b", e.nm, k, regs, {e.dis, e.msk, e.deg, e.err});
         end
      end
   endtask

   // Write data is only checked in data-phase cycles; hready low extends one.
   task automatic test_dphase_window;
      for (int k = 0; k < 4; k++) begin
         hready = (k != 1);
         if (k == 0) drive_all(2'b10, 32'h180, 1'b1, 32'hDEADBEEF);
         else begin
            drive_all(2'b00, 32'h180, 1'b0, 32'hDEADBEEF);
            rd[2] = 32'h0BADF00D;
         end
         #1;
         n_chk++;
         if (hwdata_o !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dphase_hwdata k=%0d: got %h required deadbeef", k, hwdata_o);
         end
         sbq.push_back('{"dphase_window", (k == 1 || k == 2) ? 3'b100 : 3'b000, 3'b000, 1'b0, 1'b0});
         tick;
         e = sbq.pop_front(); n_chk++;
         if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
            n_fail++; $display("FAIL %s k=%0d: dis/msk/deg/err=%b required %b", e.nm, k, regs, {e.dis, e.msk, e.deg, e.err});
         end
      end
      hready = 1'b1;
   endtask

   // One-off dissent, agreement, then three more: counter must restart at 0.
   task automatic test_addr_mismatch;
      for (int k = 0; k < 6; k++) begin
         drive_all(2'b10, 32'h100, 1'b0, '0);
         if (k != 1 && k != 5) ra[1] = 32'h104;
         #1;
         n_chk++;
         if (haddr_o !== 32'h100) begin
            n_fail++; $display("FAIL addr_vote k=%0d: got %h required 00000100", k, haddr_o);
         end
         sbq.push_back('{"addr_mismatch", (k != 1 && k != 5) ? 3'b010 : 3'b000, 3'b000, 1'b0, 1'b0});
         tick;
         e = sbq.pop_front(); n_chk++;
         if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
            n_fail++; $display("FAIL %s k=%0d: dis/msk/deg/err=%b required %b", e.nm, k, regs, {e.dis, e.msk, e.deg, e.err});
         end
      end
   endtask

   task automatic test_wdata_mask;
      for (int k = 0; k < 5; k++) begin
         drive_all((k < 4) ? 2'b10 : 2'b00, 32'h200, (k < 4), 32'hCAFEF00D);
         if (k > 0) rd[2] = ~32'hCAFEF00D;
         #1;
         n_chk++;
         if (hwdata_o !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL wdata_vote k=%0d: got %h required cafef00d", k, hwdata_o);
         end
         sbq.push_back('{"wdata_mask", (k > 0) ? 3'b100 : 3'b000, (k == 4) ? 3'b100 : 3'b000, (k == 4), 1'b0});
         tick;
         e = sbq.pop_front(); n_chk++;
         if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
            n_fail++; $display("FAIL %s k=%0d: dis/msk/deg/err=%b required %b", e.nm, k, regs, {e.dis, e.msk, e.deg, e.err});
         end
      end
   endtask

   // Two voters left: any split is unrecoverable; clear restores masks only.
   task automatic test_dmr_nomaj;
      for (int k = 0; k < 3; k++) begin
         drive_all(2'b00, 32'h240, 1'b0, '0);
         if (k == 0) begin rt[0] = 2'b10; rt[2] = 2'b11; end
         clr = (k == 1);
         #1;
         n_chk++;
         if (htrans_o !== ((k == 0) ? 2'b10 : 2'b00)) begin
            n_fail++; $display("FAIL dmr_htrans k=%0d: got %b required %b", k, htrans_o, (k == 0) ? 2'b10 : 2'b00);
         end
         sbq.push_back('{"dmr_nomaj", 3'b000, (k == 0) ? 3'b100 : 3'b000, (k == 0), 1'b1});
         tick;
         e = sbq.pop_front(); n_chk++;
         if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
            n_fail++; $display("FAIL %s k=%0d: dis/msk/deg/err=%b required %b", e.nm, k, regs, {e.dis, e.msk, e.deg, e.err});
         end
      end
      clr = 1'b0;
   endtask

   // Three-way split, then clear racing a mismatch must restart the count.
   task automatic test_all_differ;
      rstn = 1'b0; #1; rstn = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k == 0) begin
            drive_all(2'b00, 32'h300, 1'b0, '0);
            rt[1] = 2'b10; rt[2] = 2'b11;
         end else begin
            drive_all(2'b10, 32'h300, 1'b0, '0);
            ra[1] = 32'h304;
         end
         clr = (k == 4);
         #1;
         n_chk++;
         if (htrans_o !== ((k == 0) ? 2'b00 : 2'b10)) begin
            n_fail++; $display("FAIL differ_htrans k=%0d: got %b required %b", k, htrans_o, (k == 0) ? 2'b00 : 2'b10);
         end
         sbq.push_back('{"all_differ", (k == 0) ? 3'b000 : 3'b010, (k == 8) ? 3'b010 : 3'b000, (k == 8), 1'b1});
         tick;
         e = sbq.pop_front(); n_chk++;
         if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
            n_fail++; $display("FAIL %s k=%0d: dis/msk/deg/err=%b required %b", e.nm, k, regs, {e.dis, e.msk, e.deg, e.err});
         end
      end
      clr = 1'b0;
   endtask

   task automatic test_reset_mid_dphase;
      drive_all(2'b10, 32'h400, 1'b1, '0);
      sbq.push_back('{"pre_reset", 3'b000, 3'b010, 1'b1, 1'b1});
      tick;
      e = sbq.pop_front(); n_chk++;
      if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
         n_fail++; $display("FAIL %s: dis/msk/deg/err=%b required %b", e.nm, regs, {e.dis, e.msk, e.deg, e.err});
      end
      drive_all(2'b00, 32'h400, 1'b0, 32'h12345678);
      rd[0] = 32'h87654321;
      rstn = 1'b0;
      #1;
      n_chk++;
      if (regs !== '0) begin
         n_fail++; $display("FAIL async_reset: dis/msk/deg/err=%b required %b", regs, {(2*N+2){1'b0}});
      end
      rstn = 1'b1;
      #1;
      n_chk++;
      if (hwdata_o !== 32'h12345678) begin
         n_fail++; $display("FAIL reset_hwdata: got %h required 12345678", hwdata_o);
      end
      sbq.push_back('{"post_reset_unchecked", 3'b000, 3'b000, 1'b0, 1'b0});
      tick;
      e = sbq.pop_front(); n_chk++;
      if (regs !== {e.dis, e.msk, e.deg, e.err}) begin
         n_fail++; $display("FAIL %s: dis/msk/deg/err=%b required %b", e.nm, regs, {e.dis, e.msk, e.deg, e.err});
      end
   endtask

   initial begin
      test_reset;
      test_clean_write;
      test_dphase_window;
      test_addr_mismatch;
      test_wdata_mask;
      test_dmr_nomaj;
      test_all_differ;
      test_reset_mid_dphase;
      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/nmr_bus_voter.md
# nmr_bus_voter

Parametrised N-modular-redundancy voter for one AHB master port, driven by N lockstepped core replicas. It votes the address-phase and write-data-phase signals across the replicas that are still trusted, and tracks per-replica disagreement. A replica that disagrees persistently is masked out, so the port degrades gracefully from N-way voting to dual-modular compare. Sits between the replicated cores and the system bus; it generalises the fixed triple-core voting with its single discrepancy flop.

## Interface
- N, 3, replica count (3..7)
- AW, 32, address width
- DW, 32, write-data width (includes checksum bits if packed by caller)
- PW, 6, address-phase parity width
- TH, 4, consecutive-mismatch count that masks a replica (1..2^CW-1)
- CW, 3, mismatch counter width
- s_clk_i  in  1  clock (single clock for the whole block)
- s_resetn_i  in  1  asynchronous active-low reset
- s_rep_htrans_i[N]  in  2  replica htrans
- s_rep_haddr_i[N]  in  AW  replica haddr
- s_rep_hsize_i[N]  in  3  replica hsize
- s_rep_hwrite_i[N]  in  1  replica hwrite
- s_rep_hparity_i[N]  in  PW  replica address parity
- s_rep_hwdata_i[N]  in  DW  replica write data
- s_hready_i  in  1  bus hready (already voted upstream)
- s_clear_i  in  1  clears masks and counters (not the error)
- s_htrans_o, s_haddr_o, s_hsize_o, s_hwrite_o, s_hparity_o, s_hwdata_o  out  as inputs  voted bus outputs
- s_rep_masked_o  out  N  replica excluded from vote
- s_rep_disagree_o  out  N  replica lost the vote last cycle
- s_degraded_o  out  1  fewer than 3 replicas active
- s_unrec_err_o  out  1  sticky unrecoverable discrepancy

## Operation
- Active set A = unmasked replicas; |A| is always ≥ 2.
- The voter picks the value held by more than |A|/2 active replicas, strictly.
- No majority: output the value of the lowest-index active replica and raise a no-majority event.
- With |A| = 2, any difference is a no-majority event. This is compare-only (DMR) mode.
- htrans is always voted.
- haddr, hsize, hwrite and hparity are checked only when the voted htrans ≠ IDLE (2'b00). Otherwise they pass through the voter without raising events.
- Data-phase flop dphase:
  - when s_hready_i = 1, next value is (voted htrans ≠ IDLE) & voted hwrite;
  - otherwise it holds.
- hwdata is checked only while dphase = 1.
- A replica mismatches in a cycle if it is active and differs from the voted value of any field checked that cycle. This only counts in cycles with no no-majority event.
- Per-replica counter:
  - mismatch: +1, saturating at TH;
  - agreement: reset to 0;
  - masked replica: held.
- Counter reaching TH masks the replica on the same edge. Masking is allowed only if |A| ≥ 3 beforehand.
- If several replicas reach TH on one edge, mask in ascending index while |A| stays ≥ 2. The rest stay active at counter TH and are re-evaluated every cycle.
- s_unrec_err_o is set by any no-majority event. It stays set until reset, and s_clear_i does not clear it.
- s_clear_i has priority over a simultaneous mismatch. It zeroes all counters and masks at the next edge.

## Timing
- Voted bus outputs are combinational from the inputs, with zero latency.
- s_rep_disagree_o, s_unrec_err_o and s_rep_masked_o are registered and update one cycle after the offending cycle.
- Mask change affects the vote from the cycle after the masking edge.
- Reset values:
  - masks 0, counters 0, dphase 0;
  - s_rep_disagree_o 0, s_unrec_err_o 0, s_degraded_o = (N < 3 ? 1 : 0), i.e. 0 for legal N.
- Async reset mid-transfer clears dphase, so a pending write-data check is dropped.

## Structure
- Shared package:
  - HTRANS_IDLE constant;
  - replica-index width function $clog2(N).
- Sub-module nmr_vote, parametrised on N and W:
  - combinational masked majority vote;
  - outputs the voted value, a no-majority flag and a per-replica differ vector;
  - instantiated once per bus field.
- Top holds the counters, masks, dphase, error flop and masking arbitration (≈250 lines).

## Test plan
- N=3, all replicas identical, NONSEQ write to 0x100 then data 0xDEADBEEF:
  - outputs follow the replicas;
  - no disagree, no error, dphase = 1 for exactly the data cycle.
- Replica 1 haddr = 0x104 for 1 cycle while others drive 0x100 NONSEQ:
  - s_haddr_o = 0x100;
  - disagree = 3'b010 the next cycle;
  - counter[1] back to 0 after the next agreeing cycle.
- Replica 2 hwdata wrong for 4 consecutive data phases (TH=4):
  - mask = 3'b100 after the 4th edge;
  - s_degraded_o = 1;
  - s_unrec_err_o stays 0.
- Then replica 0 differs from replica 1 on htrans (NONSEQ vs IDLE):
  - s_htrans_o = replica 0 value;
  - s_unrec_err_o = 1 next cycle and stays 1 after s_clear_i.
- All three htrans differ (00/10/11):
  - s_htrans_o = 00;
  - error set next cycle;
  - s_clear_i and a mismatch asserted together give counters 0.
- Assert s_resetn_i low mid data phase with the mask set:
  - all registered outputs 0 immediately;
  - the following data cycle is not checked.
